// File: rtl/conv_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// conv_ctrl_pkg
//   Shared definitions for the convolution / max-pool / flatten sequencer:
//   - conv_state_e   : controller FSM states
//   - F_* constants  : flag bit positions, identical to the datapath's
//   - *_len helpers  : phase lengths derived from buffer / row / word sizes
//   Optional feature macro used by importers: CONV_CTRL_FLATTEN_EN.
// -----------------------------------------------------------------------------
package conv_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LOAD = 3'd1,
        ST_CONV = 3'd2,
        ST_WRL0 = 3'd3,
        ST_RDL0 = 3'd4,
        ST_POOL = 3'd5,
        ST_FLAT = 3'd6,
        ST_DONE = 3'd7
    } conv_state_e;

    localparam int FLAGS_WIDTH = 12;

    // Flag bit positions, shared with the datapath.
    localparam int F_GEN_IN_ADDR_POS    = 0;
    localparam int F_READ_IN_ENB_POS    = 1;
    localparam int F_CONV_RELU_ENB_POS  = 2;
    localparam int F_WRITE_CONV_ENB_POS = 3;
    localparam int F_GEN_CONV_ADDR_POS  = 4;
    localparam int F_READ_CONV_ENB_POS  = 5;
    localparam int F_WRITE_POOL_ENB_POS = 6;
    localparam int F_WRITE_FLAT_ENB_POS = 7;

    // Phase lengths in cycles; local_idx runs 0..len-1 in each phase.
    // The extra cycles cover the datapath's address/read pipeline latency.
    function automatic int load_len(input int in_buffer_size);
        return 3 * in_buffer_size + 2;
    endfunction

    function automatic int conv_len(input int out_buffer_size);
        return out_buffer_size + 1;
    endfunction

    function automatic int wrl0_len(input int out_buffer_size);
        return 2 * out_buffer_size + 1;
    endfunction

    function automatic int rdl0_len(input int l0_words);
        return 2 * l0_words + 2;
    endfunction

    function automatic int pool_len(input int pool_words);
        return 2 * pool_words + 1;
    endfunction

endpackage

// File: rtl/conv_flag_decode.sv
// -----------------------------------------------------------------------------
// conv_flag_decode
//   Purely combinational decode of (state, local_idx) into the 12-bit datapath
//   phase-enable flags. The controller feeds it the *next* state/index so the
//   registered flags line up with the registered local_idx.
//   Macro: CONV_CTRL_FLATTEN_EN -- when undefined the flatten enable is tied 0.
// Ports:
//   state  in  conv_state_e           state being entered
//   idx    in  LOCAL_IDX_WIDTH        index within that state
//   flags  out 12                     phase enables; bits 8..11 always 0
// -----------------------------------------------------------------------------
module conv_flag_decode
    import conv_ctrl_pkg::*;
#(
    parameter int LOCAL_IDX_WIDTH  = 16,
    parameter int IN_BUFFER_SIZE   = 16,
    parameter int F_GEN_IN_ADDR    = F_GEN_IN_ADDR_POS,
    parameter int F_READ_IN_ENB    = F_READ_IN_ENB_POS,
    parameter int F_CONV_RELU_ENB  = F_CONV_RELU_ENB_POS,
    parameter int F_WRITE_CONV_ENB = F_WRITE_CONV_ENB_POS,
    parameter int F_GEN_CONV_ADDR  = F_GEN_CONV_ADDR_POS,
    parameter int F_READ_CONV_ENB  = F_READ_CONV_ENB_POS,
    parameter int F_WRITE_POOL_ENB = F_WRITE_POOL_ENB_POS,
    parameter int F_WRITE_FLAT_ENB = F_WRITE_FLAT_ENB_POS
) (
    input  conv_state_e                state,
    input  logic [LOCAL_IDX_WIDTH-1:0] idx,
    output logic [FLAGS_WIDTH-1:0]     flags
);

    localparam logic [LOCAL_IDX_WIDTH-1:0] GEN_IN_LIMIT = LOCAL_IDX_WIDTH'(3 * IN_BUFFER_SIZE);
    // Reads trail address generation by two cycles of memory latency.
    localparam logic [LOCAL_IDX_WIDTH-1:0] READ_DELAY   = LOCAL_IDX_WIDTH'(2);

    always_comb begin
        // NOTE: every output gets a default before the case so no latch is inferred.
        flags = '0;
        case (state)
            ST_LOAD: begin
                if (idx < GEN_IN_LIMIT) flags[F_GEN_IN_ADDR] = 1'b1;
                if (idx >= READ_DELAY)  flags[F_READ_IN_ENB] = 1'b1;
            end
            ST_CONV: flags[F_CONV_RELU_ENB]  = 1'b1;
            ST_WRL0: flags[F_WRITE_CONV_ENB] = 1'b1;
            ST_RDL0: begin
                flags[F_GEN_CONV_ADDR] = 1'b1;
                if (idx >= READ_DELAY) flags[F_READ_CONV_ENB] = 1'b1;
            end
            ST_POOL: flags[F_WRITE_POOL_ENB] = 1'b1;
`ifdef CONV_CTRL_FLATTEN_EN
            ST_FLAT: flags[F_WRITE_FLAT_ENB] = 1'b1;
`endif
            default: ;
        endcase
    end

endmodule

// File: rtl/conv_controller.sv
// -----------------------------------------------------------------------------
// conv_controller
//   Sequencer for the conv / max-pool / flatten datapath. For each of ROWS
//   rows it walks LOAD -> CONV -> WRL0, then RDL0 -> POOL (-> FLAT) -> DONE.
//   All outputs are registered and change together on one edge.
//   Macro: CONV_CTRL_FLATTEN_EN -- defined: POOL -> FLAT -> DONE;
//                                  undefined: POOL -> DONE, flatten flag 0.
// Ports:
//   clk        in  1                 rising-edge clock
//   reset      in  1                 synchronous, active-high
//   ready      in  1                 host start request, sampled only in IDLE
//   busy       out 1                 high in every active phase cycle
//   done       out 1                 one-cycle pulse after the last active cycle
//   flags      out 12                datapath phase enables
//   local_idx  out LOCAL_IDX_WIDTH   index within the current phase
//   row_idx    out 8                 current row during row phases, else 0
// -----------------------------------------------------------------------------
module conv_controller
    import conv_ctrl_pkg::*;
#(
    parameter int LOCAL_IDX_WIDTH  = 16,
    parameter int IN_BUFFER_SIZE   = 16,
    parameter int OUT_BUFFER_SIZE  = 3,
    parameter int ROWS             = 64,
    parameter int L0_WORDS         = 4096,
    parameter int POOL_WORDS       = 1024,
    parameter int F_GEN_IN_ADDR    = F_GEN_IN_ADDR_POS,
    parameter int F_READ_IN_ENB    = F_READ_IN_ENB_POS,
    parameter int F_CONV_RELU_ENB  = F_CONV_RELU_ENB_POS,
    parameter int F_WRITE_CONV_ENB = F_WRITE_CONV_ENB_POS,
    parameter int F_GEN_CONV_ADDR  = F_GEN_CONV_ADDR_POS,
    parameter int F_READ_CONV_ENB  = F_READ_CONV_ENB_POS,
    parameter int F_WRITE_POOL_ENB = F_WRITE_POOL_ENB_POS,
    parameter int F_WRITE_FLAT_ENB = F_WRITE_FLAT_ENB_POS
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       ready,
    output logic                       busy,
    output logic                       done,
    output logic [FLAGS_WIDTH-1:0]     flags,
    output logic [LOCAL_IDX_WIDTH-1:0] local_idx,
    output logic [7:0]                 row_idx
);

    localparam int IW = LOCAL_IDX_WIDTH;

    // Last local_idx value of each phase.
    localparam logic [IW-1:0] LOAD_LAST = IW'(load_len(IN_BUFFER_SIZE) - 1);
    localparam logic [IW-1:0] CONV_LAST = IW'(conv_len(OUT_BUFFER_SIZE) - 1);
    localparam logic [IW-1:0] WRL0_LAST = IW'(wrl0_len(OUT_BUFFER_SIZE) - 1);
    localparam logic [IW-1:0] RDL0_LAST = IW'(rdl0_len(L0_WORDS) - 1);
    localparam logic [IW-1:0] POOL_LAST = IW'(pool_len(POOL_WORDS) - 1);
    localparam logic [IW-1:0] FLAT_LAST = IW'(pool_len(POOL_WORDS) - 1);
    localparam logic [7:0]    ROW_LAST  = 8'(ROWS - 1);

    conv_state_e            state_q, state_d;
    logic [IW-1:0]          idx_q, idx_d;
    logic [7:0]             row_q, row_d;
    logic [FLAGS_WIDTH-1:0] flags_q, flags_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;

    // Next-state, phase counter and row counter.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q + IW'(1);
        row_d   = row_q;

        case (state_q)
            ST_IDLE: begin
                idx_d = '0;
                if (ready) state_d = ST_LOAD;
            end
            ST_LOAD: begin
                if (idx_q == LOAD_LAST) begin
                    state_d = ST_CONV;
                    idx_d   = '0;
                end
            end
            ST_CONV: begin
                if (idx_q == CONV_LAST) begin
                    state_d = ST_WRL0;
                    idx_d   = '0;
                end
            end
            ST_WRL0: begin
                if (idx_q == WRL0_LAST) begin
                    idx_d = '0;
                    if (row_q < ROW_LAST) begin
                        state_d = ST_LOAD;
                        row_d   = row_q + 8'd1;
                    end else begin
                        state_d = ST_RDL0;
                        row_d   = '0;
                    end
                end
            end
            ST_RDL0: begin
                if (idx_q == RDL0_LAST) begin
                    state_d = ST_POOL;
                    idx_d   = '0;
                end
            end
            ST_POOL: begin
                if (idx_q == POOL_LAST) begin
`ifdef CONV_CTRL_FLATTEN_EN
                    state_d = ST_FLAT;
`else
                    state_d = ST_DONE;
`endif
                    idx_d   = '0;
                end
            end
            ST_FLAT: begin
                if (idx_q == FLAT_LAST) begin
                    state_d = ST_DONE;
                    idx_d   = '0;
                end
            end
            ST_DONE: begin
                // ready is deliberately not looked at here: restart only from IDLE.
                state_d = ST_IDLE;
                idx_d   = '0;
                row_d   = '0;
            end
            default: begin
                state_d = ST_IDLE;
                idx_d   = '0;
                row_d   = '0;
            end
        endcase

        busy_d = (state_d != ST_IDLE) && (state_d != ST_DONE);
        done_d = (state_d == ST_DONE);
    end

    // Flags are decoded from the values about to be registered, so the flag
    // register always agrees with local_idx on the same cycle.
    conv_flag_decode #(
        .LOCAL_IDX_WIDTH  (LOCAL_IDX_WIDTH),
        .IN_BUFFER_SIZE   (IN_BUFFER_SIZE),
        .F_GEN_IN_ADDR    (F_GEN_IN_ADDR),
        .F_READ_IN_ENB    (F_READ_IN_ENB),
        .F_CONV_RELU_ENB  (F_CONV_RELU_ENB),
        .F_WRITE_CONV_ENB (F_WRITE_CONV_ENB),
        .F_GEN_CONV_ADDR  (F_GEN_CONV_ADDR),
        .F_READ_CONV_ENB  (F_READ_CONV_ENB),
        .F_WRITE_POOL_ENB (F_WRITE_POOL_ENB),
        .F_WRITE_FLAT_ENB (F_WRITE_FLAT_ENB)
    ) u_flag_decode (
        .state (state_d),
        .idx   (idx_d),
        .flags (flags_d)
    );

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only, so every
        // register samples the pre-edge values and order of statements is irrelevant.
        if (reset) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            row_q   <= '0;
            flags_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            row_q   <= row_d;
            flags_q <= flags_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign flags     = flags_q;
    assign local_idx = idx_q;
    assign row_idx   = row_q;

endmodule

// File: doc/conv_controller.md
# conv_controller

Sequencing controller for the convolution / max-pool / flatten datapath. It sits directly upstream of the datapath and drives its `flags`, `local_idx` and `row_idx` inputs. It also owns the host `ready`/`busy` handshake for the CNN accelerator. It walks three-row input loading, 1-D conv + ReLU and Layer-0 write-back for every row, then Layer-0 readback, pooling write and (optionally) flatten write.

## Interface
Parameters:
- `LOCAL_IDX_WIDTH`, 16, width of `local_idx`.
- `IN_BUFFER_SIZE`, 16, input buffer entries per row slot.
- `OUT_BUFFER_SIZE`, 3, conv output FIFO depth.
- `ROWS`, 64, output rows per image.
- `L0_WORDS`, 4096, Layer-0 words per kernel.
- `POOL_WORDS`, 1024, pooled words per kernel.
- `F_GEN_IN_ADDR`..`F_WRITE_FLAT_ENB`, 0..7, flag bit positions, matching the datapath.

Ports (clock and reset first):
- `clk`, in, 1, single clock; all state changes on the rising edge.
- `reset`, in, 1, synchronous, active-high.
- `ready`, in, 1, host start request; sampled only in IDLE.
- `busy`, out, 1, high while any phase is active.
- `done`, out, 1, one-cycle pulse after the last active cycle.
- `flags`, out, 12, phase enables; bits 8–11 are always 0.
- `local_idx`, out, `LOCAL_IDX_WIDTH`, index within the current phase.
- `row_idx`, out, 8, current row (0..ROWS-1) during row phases; 0 otherwise.

## Operation
- States: IDLE, LOAD, CONV, WRL0, RDL0, POOL, FLAT, DONE.
- Lengths, with `local_idx` counting 0..len-1:
  - LOAD = 3·IN_BUFFER_SIZE+2 = 50.
  - CONV = OUT_BUFFER_SIZE+1 = 4.
  - WRL0 = 2·OUT_BUFFER_SIZE+1 = 7.
  - RDL0 = 2·L0_WORDS+2 = 8194.
  - POOL = 2·POOL_WORDS+1 = 2049.
  - FLAT = 2049.
- Flag decode by state and `local_idx` (only these flags are ever high):
  - LOAD: F_GEN_IN_ADDR when idx < 3·IN_BUFFER_SIZE; F_READ_IN_ENB when idx ≥ 2.
  - CONV: F_CONV_RELU_ENB for all idx.
  - WRL0: F_WRITE_CONV_ENB for all idx. The final idx (6) is out of range in the datapath, which deasserts `cwr` there.
  - RDL0: F_GEN_CONV_ADDR for all idx. The datapath drops `crd` at idx ≥ 8192. F_READ_CONV_ENB is asserted when idx ≥ 2.
  - POOL: F_WRITE_POOL_ENB for all idx.
  - FLAT: F_WRITE_FLAT_ENB for all idx.
- Transitions:
  - IDLE→LOAD when `ready`=1.
  - LOAD→CONV→WRL0 at the end of each phase.
  - WRL0→LOAD with row_idx+1 if row_idx < ROWS-1, else WRL0→RDL0.
  - RDL0→POOL.
  - POOL→FLAT (or →DONE, see Configuration).
  - FLAT→DONE.
  - DONE→IDLE unconditionally.
- `local_idx` resets to 0 on every state entry and increments by 1 per cycle. It never wraps inside a phase.
- `row_idx` holds through LOAD/CONV/WRL0 of a row and clears to 0 on entering RDL0.
- `ready` is ignored outside IDLE. A `ready` still high in the DONE cycle is not acted on until IDLE, so the earliest restart is one cycle after DONE.

## Timing
- All outputs are registered. `flags`, `local_idx` and `row_idx` change together on one edge and are mutually consistent every cycle.
- Reset values: `busy`=0, `done`=0, `flags`=0, `local_idx`=0, `row_idx`=0, state IDLE.
- `reset` asserted mid-operation returns every output to its reset value on the next edge, regardless of state.
- Start latency: `ready` sampled high at edge N gives, after edge N, `busy`=1, state LOAD, `local_idx`=0, `row_idx`=0, flags=0x001.
- `busy` is high for exactly the active-state cycles:
  - 64 rows × 61 = 3904 row cycles.
  - Plus 8194 + 2049 + 2049 post-row cycles.
  - Total 16196 (14147 without flatten).
- DONE cycle: `busy`=0, `done`=1, `flags`=0. Next cycle is IDLE with `done`=0.

## Configuration
- Macro: `CONV_CTRL_FLATTEN_EN`.
- Defined: the FLAT phase is present (POOL→FLAT→DONE).
- Undefined: POOL→DONE directly, F_WRITE_FLAT_ENB is tied to 0, and total busy cycles are 14147.

## Structure
- Package `conv_ctrl_pkg` holds:
  - the state enum;
  - flag bit-position constants shared with the datapath;
  - phase-length constants derived from the buffer/row/word parameters.
- Sub-module `conv_flag_decode`: purely combinational (state, next `local_idx`) → 12-bit flags. The top registers its output alongside `local_idx`.
- The top holds the FSM, phase counter and row counter.

## Test plan
- Reset, then `ready` pulse at cycle 10 → at cycle 11 `busy`=1, flags=0x001, `local_idx`=0; `busy` stays high 16196 cycles; `done` pulses once; `busy`=0 in the `done` cycle.
- LOAD flag windows, row 0 → flags=0x001 at idx 0–1, 0x003 at idx 2–47, 0x002 at idx 48–49; then CONV with flags=0x004 for idx 0–3.
- Row stepping → after the 61st cycle `row_idx`=1 and state LOAD; after row 63's WRL0 idx 6, state RDL0 with `row_idx`=0 and flags=0x010 at idx 0.
- RDL0 boundary → flags=0x030 at idx 2 and at idx 8193; POOL starts next cycle with flags=0x040, `local_idx`=0.
- `reset` asserted at cycle 5000 mid-operation → next cycle all outputs 0, IDLE; a new `ready` restarts from row 0.
- Build without `CONV_CTRL_FLATTEN_EN` → flags bit 7 never set; `done` follows POOL idx 2048 by one cycle; busy length 14147.
